piso_shift_tx: RTL

//  Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready

---
 rtl/piso_shift_tx_pkg.sv | 14 +
 rtl/piso_shift_tx_dff_en_rst.sv | 26 ++
 rtl/piso_shift_tx.sv | 92 +++++++++
 3 files changed

// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter: the
// IDLE/SHIFT state codes and a helper that sizes the bit counter.
package piso_shift_tx_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  function automatic int piso_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_dff_en_rst.sv
// One storage bit: a mux selects 0 on reset, d when enabled, else q,
// and feeds a plain rising-edge D flip-flop.
module dff_en_rst (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  logic w_next;
  logic r_q;

  always_comb begin
    w_next = r_q;
    if (reset)   w_next = 1'b0;
    else if (en) w_next = d;
  end

  always_ff @(posedge clk) begin
    r_q <= w_next;
  end

  assign q = r_q;

endmodule

// File: rtl/piso_shift_tx.sv
// Serialises a WIDTH-bit word MSB-first after a valid/ready load, with a
// framing valid and a flag on the LSB; back-to-back words have no gap.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = piso_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  // Handshake: a word moves when load_valid && load_ready at a rising clk.
  // load_ready never depends on load_valid; load_data is sampled only then.

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;

  logic [WIDTH-1:0] w_shreg_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_state_d;
  logic             w_shreg_en;
  logic             w_cnt_en;
  logic             w_shifting;
  logic             w_cnt_zero;
  logic             w_accept;
  piso_state_e      w_state;

  assign w_state    = piso_state_e'(r_state);
  assign w_shifting = (w_state == PISO_SHIFT);
  assign w_cnt_zero = (r_cnt == '0);

  // Ready in IDLE, or on the final bit so the next word follows with no gap.
  assign load_ready = !reset && (!w_shifting || w_cnt_zero);
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_state_d  = w_accept || (w_shifting && !w_cnt_zero);
    w_shreg_en = w_accept || w_shifting;
    w_cnt_en   = w_accept || (w_shifting && !w_cnt_zero);
    w_cnt_d    = r_cnt - 1'b1;
    w_shreg_d  = '0;
    if (w_accept) begin
      w_shreg_d = load_data;
      w_cnt_d   = CNT_W'(WIDTH - 1);
    end else if (!w_cnt_zero) begin
      w_shreg_d = {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_shreg
    dff_en_rst u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (w_shreg_en),
      .d     (w_shreg_d[g]),
      .q     (r_shreg[g])
    );
  end

  for (genvar g = 0; g < CNT_W; g++) begin : g_cnt
    dff_en_rst u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (w_cnt_en),
      .d     (w_cnt_d[g]),
      .q     (r_cnt[g])
    );
  end

  dff_en_rst u_state (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (w_state_d),
    .q     (r_state)
  );

  assign sout       = w_shifting && r_shreg[WIDTH-1];
  assign sout_valid = w_shifting;
  assign busy       = w_shifting;
  assign last       = w_shifting && w_cnt_zero;

endmodule
